// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default widths and the
// transmit-buffer state encoding.
package uart_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, followed by a rising-edge
// detector that produces a single-cycle strobe in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO feeding the UART transmitter. Integration limit: clk
// period must be >= 10 ns so tx_data holds >= 15 ns past the accept pulse.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          tx_done_tick,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  output logic          frame_done,
  output state_t        state
);

  // Handshake: tx_start is held high (and tx_data stable) for the whole of
  // LOAD; the transmitter's first tx_done_tick accepts the byte and pops it,
  // its second tx_done_tick marks the stop bit and ends the frame.

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          done_edge;
  logic          push;
  logic          pop;
  logic          frame_set;
  state_t        cur_state;
  state_t        nxt_state;

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (tx_done_tick),
    .rise (done_edge)
  );

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign state = cur_state;

  // A pop frees a slot in the same cycle, so a write while full still lands.
  assign pop  = (cur_state == LOAD) && done_edge;
  assign push = wr_en && (!full || pop);

  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    frame_set = 1'b0;
    case (cur_state)
      IDLE: begin
        if (!empty) begin
          nxt_state = LOAD;
        end
      end
      LOAD: begin
        if (done_edge) begin
          nxt_state = SEND;
        end
      end
      SEND: begin
        if (done_edge) begin
          frame_set = 1'b1;
          nxt_state = (count_nxt != '0) ? LOAD : IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign tx_start = (cur_state == LOAD);
  assign tx_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      count_q    <= count_nxt;
      overflow   <= wr_en && !push;
      frame_done <= frame_set;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule
